mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised successor to the single-purpose MAR/MDR registers: a memory access unit holding the address and data registers and running a request/complete (`mem_req`/`mem_moc`) handshake to data memory. It supports byte, halfword, word and doubleword transfers, with byte-lane steering and optional sign extension. It sits between the datapath (ALU/register-file bus) and the RAM model, and the control unit sequences it with `start`, `busy`, `done` and `err`.

## Interface
- `DW`, 32: data width; 32 or 64 only; `NB = DW/8` byte lanes.
- `AW`, 8: address width held in MAR and driven to memory.
- `TIMEOUT`, 15: maximum `REQ` cycles before abort; used only with `MEM_TIMEOUT_EN`.
- `CLK`  in  1  clock, rising edge.
- `CLR`  in  1  reset, asynchronous, active-high.
- `mar_le`  in  1  load MAR from `addr_in[AW-1:0]`; honoured in `IDLE` only.
- `addr_in`  in  DW  address bus from datapath.
- `mdr_le`  in  1  load MDR from `wdata_in`; honoured in `IDLE` only.
- `wdata_in`  in  DW  write data from datapath.
- `start`  in  1  begin access; sampled in `IDLE` only.
- `rw`  in  1  1 = read, 0 = write; sampled with `start`.
- `size`  in  2  transfer is 2^size bytes: 00 byte, 01 half, 10 word, 11 double.
- `sext`  in  1  sign-extend read data (else zero-extend); sampled with `start`.
- `busy`  out  1  high in any state other than `IDLE`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, on a failed access.
- `mar_q`  out  AW  MAR contents.
- `mdr_q`  out  DW  MDR contents.
- `mem_addr`  out  AW  equals `mar_q`.
- `mem_wdata`  out  DW  lane-replicated write data.
- `mem_be`  out  NB  byte enables.
- `mem_req`  out  1  request, registered.
- `mem_we`  out  1  write strobe, registered; valid while `mem_req` is high.
- `mem_rdata`  in  DW  read data; valid when `mem_moc` is high.
- `mem_moc`  in  1  memory operation complete.

## Operation
- States: `IDLE`, `REQ`, `DONE`, `FAIL`.
- `IDLE`:
  - `mar_le` and `mdr_le` load their registers. If `mdr_le` and `start` are high in the same cycle, the new MDR value is the write data.
  - `start` with an illegal access goes to `FAIL`. Illegal means 2^size > NB, or MAR not aligned to 2^size.
  - `start` with a legal access latches `rw`, `size`, `sext` and goes to `REQ`.
- `REQ`:
  - `mem_req` = 1, `mem_we` = !rw.
  - Byte lane is `L = MAR[log2(NB)-1:0]`. `mem_be` has 2^size consecutive bits set starting at bit L.
  - `mem_wdata` is the low 2^size bytes of MDR replicated across all lanes.
  - On `mem_moc` = 1, go to `DONE`. For a read, MDR takes `mem_rdata` lanes L..L+2^size-1, shifted to bit 0 and sign- or zero-extended to DW.
- `DONE`: `done` = 1 for one cycle, then `IDLE`.
- `FAIL`: `done` = 1 and `err` = 1 for one cycle; `mem_req` never asserts; MDR unchanged; then `IDLE`.
- While busy, `start`, `mar_le` and `mdr_le` are ignored. `mem_moc` outside `REQ` is ignored.
- On `CLR`, at any time including mid-`REQ`: state `IDLE`, MAR = 0, MDR = 0. All outputs 0, except `mem_addr` = 0 and `mem_wdata` = 0.

## Timing
- `start` sampled at edge 0 → `mem_req` high from edge 1.
- `mem_moc` sampled high at edge k → `mem_req` low and `done` high from edge k+1; MDR holds the read result from edge k+1.
- Minimum start-to-`done` is 2 cycles, with `mem_moc` already high in the first `REQ` cycle.
- Illegal access: `done` and `err` high from edge 1; `busy` low from edge 2.
- `busy` rises at edge 1 and falls at the edge after `done`. `mdr_q` changes only at a load edge or a read-completion edge.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to `REQ` and increments each `REQ` cycle without `mem_moc`.
  - When the counter reaches `TIMEOUT`, go to `FAIL`: `mem_req` drops, `done` and `err` pulse, MDR unchanged.
  - If `mem_moc` arrives in the same cycle as the terminal count, `mem_moc` wins.
- Undefined: no counter; `REQ` waits indefinitely.

## Structure
- Package `mem_access_pkg`:
  - state enum (`IDLE`/`REQ`/`DONE`/`FAIL`);
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_DOUBLE`);
  - function returning the byte-enable mask from size and lane.
- Sub-module `mem_lane_align`, combinational: write replication, and read extract plus sign/zero extension. FSM and registers stay in the top.

## Test plan
- DW=32: MAR=0x04, MDR=0xDEADBEEF, write word, `mem_moc` on the 3rd `REQ` cycle → `mem_be`=1111, `mem_we`=1, `mem_wdata`=0xDEADBEEF, `done` on the following cycle, `err`=0.
- MAR=0x07, read byte, `sext`=1, `mem_rdata`=0x80FFFFFF → MDR=0xFFFFFF80; same access with `sext`=0 → MDR=0x00000080.
- MAR=0x06, read half, `mem_rdata`=0x1234ABCD, `sext`=0 → `mem_be`=1100, MDR=0x00001234.
- MAR=0x02, word access → `FAIL`: `done`=`err`=1 at edge 1, `mem_req` never high. `size`=11 with DW=32 gives the same result.
- `CLR` pulsed while in `REQ` → immediately `mem_req`=0, `busy`=0, MAR=MDR=0; a later `mem_moc` is ignored.
- `MEM_TIMEOUT_EN`, `TIMEOUT`=15, `mem_moc` held low → `done`=`err`=1 after 15 `REQ` cycles, MDR unchanged. A second run with `mem_moc` on cycle 15 → `err`=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for mem_access_unit: FSM states, transfer-size codes and the
// byte-enable helper used by the top and its lane aligner.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // 2^size consecutive enables starting at the addressed lane.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] ones;
        case (size)
            SZ_BYTE: ones = 8'h01;
            SZ_HALF: ones = 8'h03;
            SZ_WORD: ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones << lane;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between mem_access_unit (master) and the RAM model (slave).
interface mem_access_if #(
    parameter int DW = 32,
    parameter int AW = 8
) ();
    localparam int NB = DW / 8;

    // Handshake: mem_req is held high (with addr/we/be/wdata stable) until the
    // cycle mem_moc is sampled high; that cycle completes the transfer and
    // mem_rdata is only meaningful in it. mem_moc while mem_req is low is ignored.
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [NB-1:0] mem_be;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_moc;

    modport master (
        output mem_addr, mem_wdata, mem_be, mem_req, mem_we,
        input  mem_rdata, mem_moc
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_be, mem_req, mem_we,
        output mem_rdata, mem_moc
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: write-data replication across lanes and
// read-data extraction with sign/zero extension.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    size,
    input  logic [2:0]    lane,
    input  logic          sext,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] wdata_rep,
    output logic [DW-1:0] rdata_ext
);
    localparam int NB = DW / 8;

    logic [DW-1:0] shifted;
    logic [3:0]    nbytes;
    logic          sign;

    always_comb begin
        nbytes    = size_bytes(size);
        shifted   = rdata >> {lane, 3'b000};
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            SZ_BYTE: sign = shifted[7];
            SZ_HALF: sign = shifted[15];
            SZ_WORD: sign = shifted[31];
            default: sign = shifted[DW-1];
        endcase
        // Lane i carries source byte (i mod 2^size); extension bytes copy the sign when asked.
        for (int i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = wdata[8*(i & (int'(nbytes) - 1)) +: 8];
            if (i < int'(nbytes)) rdata_ext[8*i +: 8] = shifted[8*i +: 8];
            else                  rdata_ext[8*i +: 8] = {8{sext & sign}};
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory access unit with req/moc handshake, lane steering and sign extension.
// Optional build macro MEM_TIMEOUT_EN aborts a REQ that waits TIMEOUT cycles.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          mar_le,
    input  logic [DW-1:0] addr_in,
    input  logic          mdr_le,
    input  logic [DW-1:0] wdata_in,
    input  logic          start,
    input  logic          rw,
    input  logic [1:0]    size,
    input  logic          sext,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mar_q,
    output logic [DW-1:0] mdr_q,
    output state_t        dbg_state,
    mem_access_if.master  mem
);
    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);

    state_t        state_q, state_d;
    logic [AW-1:0] mar_d;
    logic [DW-1:0] mdr_d;
    logic          rw_q, rw_d, sext_q, sext_d, req_q, req_d, we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [NB-1:0] be_q, be_d;
    logic [2:0]    lane_new;
    logic          illegal;
    logic [DW-1:0] wdata_rep, rdata_ext;
    logic          unused_addr;

    assign unused_addr = ^addr_in;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    mem_lane_align #(.DW(DW)) u_align (
        .wdata     (mdr_q),
        .size      (size_q),
        .lane      (3'(mar_q[LW-1:0])),
        .sext      (sext_q),
        .rdata     (mem.mem_rdata),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        rw_d     = rw_q;
        size_d   = size_q;
        sext_d   = sext_q;
        req_d    = 1'b0;
        we_d     = 1'b0;
        be_d     = '0;
        lane_new = '0;
        illegal  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mar_le) mar_d = addr_in[AW-1:0];
                if (mdr_le) mdr_d = wdata_in;
                // Legality is judged on the MAR value that will be in effect for the access.
                lane_new = 3'(mar_d[LW-1:0]);
                illegal  = (size > 2'(LW)) ||
                           ((lane_new & 3'(size_bytes(size) - 4'd1)) != 3'd0);
                if (start) begin
                    if (illegal) begin
                        state_d = FAIL;
                    end else begin
                        state_d = REQ;
                        rw_d    = rw;
                        size_d  = size;
                        sext_d  = sext;
                        req_d   = 1'b1;
                        we_d    = !rw;
                        be_d    = NB'(be_mask(size, lane_new));
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            REQ: begin
                req_d = 1'b1;
                we_d  = we_q;
                be_d  = be_q;
                if (mem.mem_moc) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    if (rw_q) mdr_d = rdata_ext;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = FAIL;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE) || (state_q == FAIL);
    assign err           = (state_q == FAIL);
    assign dbg_state     = state_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = wdata_rep;
    assign mem.mem_be    = be_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (DW=32): reset, directed vector table, reset-in-REQ,
// optional timeout cases, and randomized accesses against a reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TIMEOUT = 15;

    logic          CLK = 1'b0;
    logic          CLR = 1'b1;
    logic          mar_le, mdr_le, start, rw, sext;
    logic [DW-1:0] addr_in, wdata_in;
    logic [1:0]    size;
    logic          busy, done, err;
    logic [AW-1:0] mar_q;
    logic [DW-1:0] mdr_q;
    state_t        dbg_state;

    mem_access_if #(.DW(DW), .AW(AW)) mbus ();

    mem_access_unit #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK), .CLR (CLR), .mar_le (mar_le), .addr_in (addr_in),
        .mdr_le (mdr_le), .wdata_in (wdata_in), .start (start), .rw (rw),
        .size (size), .sext (sext), .busy (busy), .done (done), .err (err),
        .mar_q (mar_q), .mdr_q (mdr_q), .dbg_state (dbg_state), .mem (mbus)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  mar;
        logic [31:0] mdr;
        logic        rw;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] rdat;
        int          moc;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] nmdr;
        logic        err;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic idle_inputs();
        mar_le = 1'b0; mdr_le = 1'b0; start = 1'b0;
        rw = 1'b0; size = 2'd0; sext = 1'b0;
    endtask

    // Reference: transfer of 2^sz bytes at lane mar%4 on a 4-lane bus.
    function automatic void model(input logic [7:0] mar, input logic [31:0] mdr, input logic rw_i,
                                  input logic [1:0] sz, input logic sx, input logic [31:0] rdat,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] nmdr, output logic e);
        longint unsigned nb, lane, m, r, v, w;
        nb   = 64'd1 << sz;
        lane = mar % 4;
        m    = mdr;
        r    = rdat;
        e    = (nb > 4) || ((mar % nb) != 0);
        be   = 4'((((64'd1 << nb) - 1) << lane) & 64'hF);
        w    = 0;
        for (int i = 0; i < 4; i++) w |= ((m >> (8 * (i % nb))) & 64'hFF) << (8 * i);
        wd   = w[31:0];
        nmdr = mdr;
        if (!e && rw_i) begin
            v = (r >> (8 * lane)) & ((64'd1 << (8 * nb)) - 1);
            if (sx && v >= (64'd1 << (8 * nb - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * nb));
            nmdr = v[31:0];
        end
    endfunction

    // Driver: loads MAR/MDR with start, answers with mem_moc in REQ cycle moc_cyc.
    // Entered and left at a falling edge. poke drives loads/start while busy.
    task automatic run_access(input string tag, input logic [7:0] mar, input logic [31:0] mdr,
                              input logic rw_i, input logic [1:0] sz, input logic sx,
                              input logic [31:0] rdat, input int moc_cyc, input bit poke,
                              input logic [3:0] e_be, input logic [31:0] e_wd,
                              input logic [31:0] e_mdr, input logic e_err);
        logic [31:0] want;
        exp_q.push_back(e_mdr);
        mar_le = 1'b1; addr_in = {$urandom_range(0, 32'hFF_FFFF), mar};
        mdr_le = 1'b1; wdata_in = mdr;
        start = 1'b1; rw = rw_i; size = sz; sext = sx;
        mbus.mem_rdata = rdat; mbus.mem_moc = 1'b0;
        @(negedge CLK);
        if (poke) begin
            mar_le = 1'b1; addr_in = $urandom; mdr_le = 1'b1; wdata_in = $urandom;
            start = 1'b1; rw = ~rw_i;
        end else begin
            idle_inputs();
        end
        if (e_err) begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_err"}, err, 1);
            chk({tag, "_req"}, mbus.mem_req, 0);
            chk({tag, "_busy"}, busy, 1);
            @(negedge CLK);
            idle_inputs();
            chk({tag, "_busy_end"}, busy, 0);
            chk({tag, "_req_end"}, mbus.mem_req, 0);
        end else begin
            for (int n = 1; n <= moc_cyc; n++) begin
                chk({tag, "_req"}, mbus.mem_req, 1);
                chk({tag, "_done_early"}, done, 0);
                if (n == 1) begin
                    chk({tag, "_we"}, mbus.mem_we, !rw_i);
                    chk({tag, "_be"}, mbus.mem_be, e_be);
                    chk({tag, "_wdata"}, mbus.mem_wdata, e_wd);
                    chk({tag, "_addr"}, mbus.mem_addr, mar);
                    chk({tag, "_busy"}, busy, 1);
                end
                if (n == moc_cyc) mbus.mem_moc = 1'b1;
                @(negedge CLK);
            end
            mbus.mem_moc = 1'b0;
            idle_inputs();
            chk({tag, "_done"}, done, 1);
            chk({tag, "_err"}, err, 0);
            chk({tag, "_req_off"}, mbus.mem_req, 0);
            @(negedge CLK);
            chk({tag, "_busy_end"}, busy, 0);
            chk({tag, "_done_end"}, done, 0);
        end
        chk({tag, "_mar"}, mar_q, mar);
        want = exp_q.pop_front();
        chk({tag, "_mdr"}, mdr_q, want);
    endtask

    initial begin
        logic [7:0]  r_mar;
        logic [31:0] r_mdr, r_rdat, m_wd, m_mdr;
        logic [1:0]  r_sz;
        logic        r_rw, r_sx, m_err;
        logic [3:0]  m_be;

        tv[0]  = '{8'h04, 32'hDEADBEEF, 1'b0, 2'd2, 1'b0, 32'h00000000, 3, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tv[1]  = '{8'h07, 32'h11223344, 1'b1, 2'd0, 1'b1, 32'h80FFFFFF, 2, 4'h8, 32'h44444444, 32'hFFFFFF80, 1'b0};
        tv[2]  = '{8'h07, 32'h11223344, 1'b1, 2'd0, 1'b0, 32'h80FFFFFF, 1, 4'h8, 32'h44444444, 32'h00000080, 1'b0};
        tv[3]  = '{8'h06, 32'hCAFE5678, 1'b1, 2'd1, 1'b0, 32'h1234ABCD, 2, 4'hC, 32'h56785678, 32'h00001234, 1'b0};
        tv[4]  = '{8'h02, 32'h01020304, 1'b1, 2'd2, 1'b0, 32'h00000000, 1, 4'h0, 32'h00000000, 32'h01020304, 1'b1};
        tv[5]  = '{8'h00, 32'h0A0B0C0D, 1'b0, 2'd3, 1'b0, 32'h00000000, 1, 4'h0, 32'h00000000, 32'h0A0B0C0D, 1'b1};
        tv[6]  = '{8'h05, 32'h000000A5, 1'b0, 2'd0, 1'b0, 32'h00000000, 1, 4'h2, 32'hA5A5A5A5, 32'h000000A5, 1'b0};
        tv[7]  = '{8'h02, 32'h0000BEEF, 1'b0, 2'd1, 1'b0, 32'h00000000, 2, 4'hC, 32'hBEEFBEEF, 32'h0000BEEF, 1'b0};
        tv[8]  = '{8'h03, 32'h55555555, 1'b0, 2'd1, 1'b0, 32'h00000000, 1, 4'h0, 32'h00000000, 32'h55555555, 1'b1};
        tv[9]  = '{8'h08, 32'h00000000, 1'b1, 2'd2, 1'b1, 32'h87654321, 4, 4'hF, 32'h00000000, 32'h87654321, 1'b0};
        tv[10] = '{8'h02, 32'h00000000, 1'b1, 2'd1, 1'b1, 32'h9ABC0000, 1, 4'hC, 32'h00000000, 32'hFFFF9ABC, 1'b0};
        tv[11] = '{8'h01, 32'hFFFFFFFF, 1'b1, 2'd0, 1'b1, 32'h00007F00, 2, 4'h2, 32'hFFFFFFFF, 32'h0000007F, 1'b0};

        idle_inputs();
        addr_in = '0; wdata_in = '0;
        mbus.mem_rdata = '0; mbus.mem_moc = 1'b0;
        CLR = 1'b1;
        repeat (2) @(negedge CLK);

        // reset state
        chk("rst_state", dbg_state, IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", mbus.mem_req, 0);
        chk("rst_we", mbus.mem_we, 0);
        chk("rst_be", mbus.mem_be, 0);
        chk("rst_addr", mbus.mem_addr, 0);
        chk("rst_wdata", mbus.mem_wdata, 0);
        chk("rst_mar", mar_q, 0);
        chk("rst_mdr", mdr_q, 0);
        CLR = 1'b0;
        @(negedge CLK);

        // mem_moc in IDLE is ignored
        mbus.mem_moc = 1'b1; mbus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        chk("idle_moc_busy", busy, 0);
        chk("idle_moc_done", done, 0);
        chk("idle_moc_mdr", mdr_q, 0);
        mbus.mem_moc = 1'b0;

        // MAR load alone
        mar_le = 1'b1; addr_in = 32'hABCD_0033;
        @(negedge CLK);
        mar_le = 1'b0;
        chk("mar_load", mar_q, 8'h33);
        chk("mar_load_busy", busy, 0);

        for (int i = 0; i < 12; i++) begin
            run_access($sformatf("tv%0d", i), tv[i].mar, tv[i].mdr, tv[i].rw, tv[i].sz, tv[i].sx,
                       tv[i].rdat, tv[i].moc, bit'(i % 2), tv[i].be, tv[i].wd, tv[i].nmdr, tv[i].err);
        end

        // reset in the middle of REQ, later mem_moc must do nothing
        mbus.mem_rdata = 32'hFFFF_FFFF;
        mar_le = 1'b1; addr_in = 32'h10; mdr_le = 1'b1; wdata_in = 32'h55;
        start = 1'b1; rw = 1'b1; size = 2'd2; sext = 1'b0;
        @(negedge CLK);
        idle_inputs();
        chk("clr_pre_req", mbus.mem_req, 1);
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        chk("clr_req", mbus.mem_req, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_mar", mar_q, 0);
        chk("clr_mdr", mdr_q, 0);
        chk("clr_wdata", mbus.mem_wdata, 0);
        @(negedge CLK);
        CLR = 1'b0;
        mbus.mem_moc = 1'b1;
        repeat (2) @(negedge CLK);
        chk("clr_moc_done", done, 0);
        chk("clr_moc_busy", busy, 0);
        chk("clr_moc_req", mbus.mem_req, 0);
        chk("clr_moc_mdr", mdr_q, 0);
        mbus.mem_moc = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // mem_moc never arrives: abort after TIMEOUT REQ cycles
        mar_le = 1'b1; addr_in = 32'h0; mdr_le = 1'b1; wdata_in = 32'h1234_5678;
        start = 1'b1; rw = 1'b1; size = 2'd2; sext = 1'b0;
        @(negedge CLK);
        idle_inputs();
        for (int n = 1; n <= TIMEOUT; n++) begin
            chk("tmo_req", mbus.mem_req, 1);
            @(negedge CLK);
        end
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_req_off", mbus.mem_req, 0);
        chk("tmo_mdr", mdr_q, 32'h1234_5678);
        @(negedge CLK);
        chk("tmo_busy_end", busy, 0);
        // mem_moc on the terminal cycle wins
        run_access("tmo_moc", 8'h00, 32'h0, 1'b1, 2'd2, 1'b0, 32'hA5A5_5A5A, TIMEOUT, 1'b0,
                   4'hF, 32'h0, 32'hA5A5_5A5A, 1'b0);
`else
        // REQ waits as long as it takes
        run_access("long_wait", 8'h0C, 32'h0, 1'b1, 2'd2, 1'b0, 32'h0BAD_F00D, 20, 1'b0,
                   4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);
`endif

        // randomized accesses against the reference model
        for (int k = 0; k < 40; k++) begin
            r_mar  = 8'($urandom_range(0, 255));
            r_sz   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && r_sz != 2'd3) r_mar = r_mar & ~8'((1 << r_sz) - 1);
            r_mdr  = $urandom;
            r_rdat = $urandom;
            r_rw   = 1'($urandom_range(0, 1));
            r_sx   = 1'($urandom_range(0, 1));
            model(r_mar, r_mdr, r_rw, r_sz, r_sx, r_rdat, m_be, m_wd, m_mdr, m_err);
            run_access($sformatf("rnd%0d", k), r_mar, r_mdr, r_rw, r_sz, r_sx, r_rdat,
                       $urandom_range(1, 4), 1'($urandom_range(0, 1)), m_be, m_wd, m_mdr, m_err);
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
